// File: rtl/morse_press_classifier.sv
// Measures debounced key press/gap durations, classifies dots and dashes,
// and assembles up to five symbols into a letter, flagging letter and word gaps.
module morse_press_classifier #(
    parameter int unsigned TICK_DIV   = 1_000_000,
    parameter int unsigned MIN_PRESS  = 2,
    parameter int unsigned DOT_MAX    = 20,
    parameter int unsigned LETTER_GAP = 30,
    parameter int unsigned WORD_GAP   = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic       letter_valid,
    output logic [4:0] letter_code,
    output logic [2:0] letter_len,
    output logic       letter_overflow,
    output logic       word_gap
);

    localparam int unsigned PW      = $clog2(TICK_DIV);
    localparam int unsigned CW      = $clog2(WORD_GAP + 1);
    localparam int unsigned MAX_SYM = 5;

    typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

    state_t        state;
    logic          key_q;
    logic [PW-1:0] presc;
    logic [CW-1:0] press_cnt;
    logic [CW-1:0] gap_cnt;
    logic [4:0]    sym_buf;
    logic [2:0]    len;
    logic          ovf;

    logic          rise;
    logic          fall;
    logic          tick;
    logic          is_dash;
    logic [CW-1:0] press_inc;
    logic [CW-1:0] gap_inc;

    assign rise      = key & ~key_q;
    assign fall      = ~key & key_q;
    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign is_dash   = (press_cnt >= CW'(DOT_MAX));
    // Both duration counters saturate at the word gap so a held key cannot wrap.
    assign press_inc = (press_cnt == CW'(WORD_GAP)) ? press_cnt : press_cnt + CW'(1);
    assign gap_inc   = (gap_cnt == CW'(WORD_GAP)) ? gap_cnt : gap_cnt + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            key_q           <= 1'b0;
            presc           <= '0;
            press_cnt       <= '0;
            gap_cnt         <= '0;
            sym_buf         <= '0;
            len             <= '0;
            ovf             <= 1'b0;
            sym_valid       <= 1'b0;
            sym_dash        <= 1'b0;
            letter_valid    <= 1'b0;
            letter_code     <= '0;
            letter_len      <= '0;
            letter_overflow <= 1'b0;
            word_gap        <= 1'b0;
        end else begin
            key_q        <= key;
            sym_valid    <= 1'b0;
            letter_valid <= 1'b0;
            word_gap     <= 1'b0;

            // Prescaler restarts on every key edge so durations align to the edge.
            if (rise || fall || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state     <= PRESS;
                        press_cnt <= '0;
                    end
                end
                PRESS: begin
                    if (fall) begin
                        gap_cnt <= '0;
                        if (press_cnt < CW'(MIN_PRESS)) begin
                            state <= (len != 3'd0) ? GAP : IDLE;
                        end else begin
                            sym_valid <= 1'b1;
                            sym_dash  <= is_dash;
                            if (len < 3'(MAX_SYM)) begin
                                sym_buf[len] <= is_dash;
                                len          <= len + 3'd1;
                            end else begin
                                ovf <= 1'b1;
                            end
                            state <= GAP;
                        end
                    end else if (tick) begin
                        press_cnt <= press_inc;
                    end
                end
                GAP: begin
                    // A new press wins over a closing tick; the letter stays open.
                    if (rise) begin
                        state     <= PRESS;
                        press_cnt <= '0;
                    end else if (tick) begin
                        gap_cnt <= gap_inc;
                        if (gap_inc == CW'(LETTER_GAP) && len != 3'd0) begin
                            letter_valid    <= 1'b1;
                            letter_code     <= sym_buf;
                            letter_len      <= len;
                            letter_overflow <= ovf;
                            sym_buf         <= '0;
                            len             <= '0;
                            ovf             <= 1'b0;
                        end
                        if (gap_inc == CW'(WORD_GAP)) begin
                            word_gap <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_press_classifier.sv
// Directed bench for morse_press_classifier with a small time unit (4 clk per unit).
module tb_morse_press_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key;
    logic       sym_valid;
    logic       sym_dash;
    logic       letter_valid;
    logic [4:0] letter_code;
    logic [2:0] letter_len;
    logic       letter_overflow;
    logic       word_gap;

    int checks   = 0;
    int failures = 0;

    morse_press_classifier #(
        .TICK_DIV  (4),
        .MIN_PRESS (1),
        .DOT_MAX   (3),
        .LETTER_GAP(3),
        .WORD_GAP  (7)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key            (key),
        .sym_valid      (sym_valid),
        .sym_dash       (sym_dash),
        .letter_valid   (letter_valid),
        .letter_code    (letter_code),
        .letter_len     (letter_len),
        .letter_overflow(letter_overflow),
        .word_gap       (word_gap)
    );

    always #5 clk = ~clk;

    // Event log filled from the outputs, sampled on the falling edge.
    int         sym_total    = 0;
    int         letter_total = 0;
    int         word_total   = 0;
    logic       sym_log [0:255];
    logic [4:0] last_code = '0;
    logic [2:0] last_len  = '0;
    logic       last_ovf  = 1'b0;

    always @(negedge clk) begin
        if (sym_valid) begin
            sym_log[sym_total & 255] = sym_dash;
            sym_total++;
        end
        if (letter_valid) begin
            last_code = letter_code;
            last_len  = letter_len;
            last_ovf  = letter_overflow;
            letter_total++;
        end
        if (word_gap) word_total++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        key = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " sym_valid"},       32'(sym_valid), 32'd0);
        check({tag, " sym_dash"},        32'(sym_dash), 32'd0);
        check({tag, " letter_valid"},    32'(letter_valid), 32'd0);
        check({tag, " letter_code"},     32'(letter_code), 32'd0);
        check({tag, " letter_len"},      32'(letter_len), 32'd0);
        check({tag, " letter_overflow"}, 32'(letter_overflow), 32'd0);
        check({tag, " word_gap"},        32'(word_gap), 32'd0);
    endtask

    typedef struct {
        string      name;
        int         n_press;
        int         press_len [6];
        int         gap_len;
        int         tail;
        int         exp_sym;
        logic [5:0] exp_dash;
        int         exp_letters;
        logic [4:0] exp_code;
        logic [2:0] exp_len;
        logic       exp_ovf;
        int         exp_words;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int s0, l0, w0, ns;
        logic [5:0] dash_bits;

        vecs[0] = '{"single_dot",  1, '{8, 0, 0, 0, 0, 0},  0, 40, 1, 6'b000000, 1, 5'b00000, 3'd1, 1'b0, 1};
        vecs[1] = '{"dash_dot",    2, '{16, 8, 0, 0, 0, 0}, 6, 40, 2, 6'b000001, 1, 5'b00001, 3'd2, 1'b0, 1};
        vecs[2] = '{"glitch_drop", 2, '{3, 8, 0, 0, 0, 0},  4, 40, 1, 6'b000000, 1, 5'b00000, 3'd1, 1'b0, 1};
        vecs[3] = '{"overflow",    6, '{8, 8, 8, 8, 8, 8},  4, 40, 6, 6'b000000, 1, 5'b00000, 3'd5, 1'b1, 1};
        vecs[4] = '{"dd_dot",      3, '{16, 16, 8, 0, 0, 0}, 8, 40, 3, 6'b000011, 1, 5'b00011, 3'd3, 1'b0, 1};
        vecs[5] = '{"held_key",    1, '{60, 0, 0, 0, 0, 0}, 0, 40, 1, 6'b000001, 1, 5'b00001, 3'd1, 1'b0, 1};

        key   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            s0 = sym_total;
            l0 = letter_total;
            w0 = word_total;
            for (int i = 0; i < vecs[v].n_press; i++) begin
                drive(1'b1, vecs[v].press_len[i]);
                drive(1'b0, (i == vecs[v].n_press - 1) ? vecs[v].tail : vecs[v].gap_len);
            end
            ns = sym_total - s0;
            dash_bits = '0;
            for (int k = 0; k < 6; k++) begin
                if (k < ns) dash_bits[k] = sym_log[(s0 + k) & 255];
            end
            check({vecs[v].name, " sym_count"},    32'(ns), 32'(vecs[v].exp_sym));
            check({vecs[v].name, " sym_dash_seq"}, 32'(dash_bits), 32'(vecs[v].exp_dash));
            check({vecs[v].name, " letters"},      32'(letter_total - l0), 32'(vecs[v].exp_letters));
            check({vecs[v].name, " code"},         32'(last_code), 32'(vecs[v].exp_code));
            check({vecs[v].name, " len"},          32'(last_len), 32'(vecs[v].exp_len));
            check({vecs[v].name, " ovf"},          32'(last_ovf), 32'(vecs[v].exp_ovf));
            check({vecs[v].name, " word_gaps"},    32'(word_total - w0), 32'(vecs[v].exp_words));
        end

        // Exact strobe latencies and widths for one dot.
        drive(1'b1, 8);
        key = 1'b0;
        @(negedge clk);
        check("lat sym_valid_hi", 32'(sym_valid), 32'd1);
        check("lat sym_dash", 32'(sym_dash), 32'd0);
        @(negedge clk);
        check("lat sym_valid_lo", 32'(sym_valid), 32'd0);
        check("lat letter_early", 32'(letter_valid), 32'd0);
        repeat (11) @(negedge clk);
        check("lat letter_valid_hi", 32'(letter_valid), 32'd1);
        check("lat letter_len", 32'(letter_len), 32'd1);
        @(negedge clk);
        check("lat letter_valid_lo", 32'(letter_valid), 32'd0);
        repeat (15) @(negedge clk);
        check("lat word_gap_hi", 32'(word_gap), 32'd1);
        @(negedge clk);
        check("lat word_gap_lo", 32'(word_gap), 32'd0);
        repeat (10) @(negedge clk);

        // Reset mid-letter discards two dashes.
        drive(1'b1, 16);
        drive(1'b0, 4);
        drive(1'b1, 16);
        drive(1'b0, 2);
        check("midrst sym_dash_before", 32'(sym_dash), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs_zero("midrst");
        l0 = letter_total;
        w0 = word_total;
        drive(1'b0, 40);
        check("midrst no_letter", 32'(letter_total - l0), 32'd0);
        check("midrst no_word", 32'(word_total - w0), 32'd0);
        drive(1'b1, 8);
        drive(1'b0, 40);
        check("midrst next_letters", 32'(letter_total - l0), 32'd1);
        check("midrst next_len", 32'(last_len), 32'd1);
        check("midrst next_code", 32'(last_code), 32'd0);

        // Rise on the exact closing tick keeps the letter open.
        l0 = letter_total;
        drive(1'b1, 16);
        drive(1'b0, 12);
        drive(1'b1, 8);
        drive(1'b0, 40);
        check("race letters", 32'(letter_total - l0), 32'd1);
        check("race len", 32'(last_len), 32'd2);
        check("race code", 32'(last_code), 32'd1);

        // One cycle later the letter closes before the next press.
        l0 = letter_total;
        drive(1'b1, 16);
        drive(1'b0, 13);
        drive(1'b1, 8);
        drive(1'b0, 40);
        check("late letters", 32'(letter_total - l0), 32'd2);
        check("late len", 32'(last_len), 32'd1);
        check("late code", 32'(last_code), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
